// File: rtl/iterative_right_shift_unit.sv
// Multi-cycle right shifter: one bit position per clock, valid/ready on both sides.
// Supports logical, arithmetic, rotate and rotate-through-carry shifts.
module iterative_right_shift_unit #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  logic                  cf_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [WORD_WIDTH-1:0] r_o,
  output logic                  cf_o
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_LSR = 2'b00,
    OP_ASR = 2'b01,
    OP_ROR = 2'b10,
    OP_RRC = 2'b11
  } op_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic                  carry_q, carry_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fill;
  logic                  unused_b_hi;

  // Only the low log2(WORD_WIDTH) bits of the amount matter.
  assign unused_b_hi = ^b_i[WORD_WIDTH-1:CNT_W];

  // Bit entering at the MSB for the current step.
  always_comb begin
    fill = 1'b0;
    case (op_q)
      OP_LSR: fill = 1'b0;
      OP_ASR: fill = data_q[WORD_WIDTH-1];
      OP_ROR: fill = data_q[0];
      OP_RRC: fill = carry_q;
      default: fill = 1'b0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          data_d  = a_i;
          carry_d = cf_i;
          op_d    = op_t'(op_i);
          cnt_d   = b_i[CNT_W-1:0];
          state_d = (b_i[CNT_W-1:0] == CNT_W'(0)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        carry_d = data_q[0];
        data_d  = {fill, data_q[WORD_WIDTH-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and handshake registers; handshake flags track the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      op_q    <= OP_LSR;
      data_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == DONE);
    end
  end

  assign r_o  = data_q;
  assign cf_o = carry_q;

endmodule

// File: tb/tb_iterative_right_shift_unit.sv
// Self-checking bench for iterative_right_shift_unit: directed vectors plus random ops
// against an arithmetic reference model.
module tb_iterative_right_shift_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   op_i;
  logic         cf_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] r_o;
  logic         cf_o;

  int           checks = 0;
  int           errors = 0;
  logic         chk_en;
  logic [W-1:0] exp_r;
  logic         exp_cf;

  iterative_right_shift_unit #(.WORD_WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .cf_i    (cf_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .r_o     (r_o),
    .cf_o    (cf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {cf_o, r_o} from plain shift/rotate arithmetic.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic cf);
    int unsigned n;
    logic [W:0]   v;
    logic [W-1:0] r;
    n = b % W;
    if (n == 0) return {cf, a};
    case (op)
      2'd0: r = a >> n;
      2'd1: r = W'($signed(a) >>> n);
      2'd2: r = W'((a >> n) | (a << (W - n)));
      default: begin
        v = {cf, a};
        v = (W+1)'((v >> n) | (v << (W + 1 - n)));
        return v;
      end
    endcase
    return {a[n-1], r};
  endfunction

  // While a result is presented it must match the model and be held stable.
  always @(negedge clk) begin
    if (chk_en && !rst_i && valid_o) begin
      check("r_o", 32'(r_o), 32'(exp_r));
      check("cf_o", 32'(cf_o), 32'(exp_cf));
      check("ready_o_in_done", 32'(ready_o), 32'd0);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!ready_o && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("ready_wait", 32'(ready_o), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cf, input int hold);
    int unsigned n = b % W;
    logic [W:0]  m;
    int          k;
    m = model(op, a, b, cf);
    wait_ready();
    exp_r   = m[W-1:0];
    exp_cf  = m[W];
    ready_i = 1'b0;
    valid_i = 1'b1;
    op_i = op; a_i = a; b_i = b; cf_i = cf;
    @(posedge clk); #1;
    valid_i = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); op_i = 2'($urandom); cf_i = 1'($urandom);
    k = 0;
    while (!valid_o && k < int'(W) + 2) begin
      check("ready_low_busy", 32'(ready_o), 32'd0);
      valid_i = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    check("latency", 32'(k), 32'(n));
    repeat (hold) begin
      valid_i = 1'($urandom);
      a_i = W'($urandom);
      @(posedge clk); #1;
      check("valid_hold", 32'(valid_o), 32'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    check("valid_after_hs", 32'(valid_o), 32'd0);
    check("ready_after_hs", 32'(ready_o), 32'd1);
  endtask

  task automatic reset_mid_shift();
    wait_ready();
    valid_i = 1'b1;
    op_i = 2'd1; a_i = 8'hF3; b_i = 8'd6; cf_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst_i  = 1'b1;
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_r", 32'(r_o), 32'd0);
    check("rst_cf", 32'(cf_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", 32'(valid_o), 32'd0);
    chk_en = 1'b1;
  endtask

  logic [1:0]   d_op [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [W-1:0] d_a  [7] = '{8'hB4, 8'h96, 8'h81, 8'h01, 8'h01, 8'h5A, 8'hB4};
  logic [W-1:0] d_b  [7] = '{8'd3, 8'd2, 8'd1, 8'd1, 8'd7, 8'h00, 8'h0A};
  logic         d_cf [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [W:0]   d_exp[7] = '{9'h116, 9'h1E5, 9'h1C0, 9'h100, 9'h006, 9'h15A, 9'h02D};

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; cf_i = 1'b0; a_i = '0; b_i = '0;
    chk_en = 1'b1; exp_r = '0; exp_cf = 1'b0;
    #12;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_r", 32'(r_o), 32'd0);
    check("reset_cf", 32'(cf_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      check($sformatf("model_pin%0d", i), 32'(model(d_op[i], d_a[i], d_b[i], d_cf[i])),
            32'(d_exp[i]));
      run_op(d_op[i], d_a[i], d_b[i], d_cf[i], (i == 0) ? 5 : i % 3);
    end

    reset_mid_shift();
    run_op(2'd3, 8'h01, 8'd7, 1'b1, 1);

    for (int i = 0; i < 60; i++) begin
      run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/iterative_right_shift_unit.md
# iterative_right_shift_unit

Multi-cycle right-shift unit for the ALU. It is the right-direction counterpart of the combinational left shift unit. It accepts an operand, a shift amount, a shift type and a carry-in over a valid/ready handshake, then shifts one bit position per clock. It returns the result and the carry-out over a second valid/ready handshake. It serves ALU configurations that trade latency for area instead of using a full barrel shifter.

## Interface
- WORD_WIDTH, default 8: operand/result width; power of two, ≥ 4.
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- op_i  input  2  shift type: 00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry.
- cf_i  input  1  carry-in.
- a_i  input  WORD_WIDTH  operand to shift.
- b_i  input  WORD_WIDTH  shift amount; only b_i[$clog2(WORD_WIDTH)-1:0] is used, upper bits are ignored.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- r_o  output  WORD_WIDTH  shifted result.
- cf_o  output  1  carry-out.

## Operation
- FSM states:
  - IDLE: ready_o=1, valid_o=0.
  - SHIFT: ready_o=0, valid_o=0.
  - DONE: ready_o=0, valid_o=1.
- Accept: an edge in IDLE with valid_i=1.
  - Captures data←a_i, carry←cf_i, op←op_i, cnt←n, where n = b_i[$clog2(WORD_WIDTH)-1:0].
  - Next state is DONE if n=0, otherwise SHIFT.
- One step per edge in SHIFT, for all op types:
  - carry←data[0].
  - data←{fill, data[WORD_WIDTH-1:1]}.
  - cnt←cnt-1.
  - When cnt=1 at that edge, next state is DONE.
- Fill bit by op:
  - 00: 0.
  - 01: data[WORD_WIDTH-1].
  - 10: data[0].
  - 11: carry (pre-step value), giving a (WORD_WIDTH+1)-bit rotate.
- Result: r_o=data and cf_o=carry, driven directly from registers.
  - For n=0: r_o=a_i and cf_o=cf_i as captured.
  - For n>0: cf_o is the last bit shifted out.
- Return: while in DONE, r_o and cf_o are held stable. An edge with ready_i=1 moves to IDLE. ready_i=0 holds DONE indefinitely.
- valid_i, a_i, b_i, op_i and cf_i are ignored outside IDLE. Captured values are unaffected by input changes mid-operation.
- Reset, asserted at any time including mid-SHIFT or in DONE, has immediate effect:
  - state=IDLE, data=0, carry=0, cnt=0.
  - Therefore ready_o=1, valid_o=0, r_o=0, cf_o=0.
  - Any in-flight operation is discarded. No result is produced.

## Timing
- Accept on edge E0. valid_o rises after edge E0+n, i.e. n cycles after acceptance; for n=0 it rises in the cycle right after E0.
- Throughput: at most one operation per n+2 cycles (accept, n shifts, at least one DONE cycle). There is no back-to-back accept: ready_o is low in the DONE exit cycle and returns high the cycle after the handshake.
- Maximum latency is WORD_WIDTH-1 shift cycles.
- ready_o and valid_o are pure functions of state; there is no combinational path from any input to any output.

## Test plan
All cases use WORD_WIDTH=8.
- Logical: op=00, a=0xB4, b=3, cf=0 -> valid_o after 3 edges, r=0x16, cf_o=1. ready_o stays low from the accept edge until the cycle after the result handshake.
- Arithmetic and rotate:
  - op=01, a=0x96, b=2 -> r=0xE5, cf_o=1.
  - op=10, a=0x81, b=1 -> r=0xC0, cf_o=1.
- Rotate-through-carry:
  - op=11, a=0x01, cf=0, b=1 -> r=0x00, cf_o=1.
  - op=11, a=0x01, cf=1, b=7 -> r=0x06, cf_o=0.
- Zero/masked amount:
  - b=0x00, a=0x5A, cf=1 -> valid_o in the next cycle, r=0x5A, cf_o=1.
  - b=0x0A -> shifts by 2, latency 2.
- Backpressure: ready_i=0 for 5 cycles in DONE -> r_o and cf_o are stable and valid_o stays 1. Toggling valid_i or a_i in that window has no effect. ready_i=1 -> IDLE next cycle.
- Reset mid-operation: assert rst_i between edges during a b=6 shift -> outputs are 0, ready_o=1, valid_o=0 immediately, before the next clock edge. After release, a new request completes correctly.
